// File: rtl/csr_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : csr_reg_file
//  Purpose  : Machine-mode CSR file for the RV32 core. Combinational read of
//             the old value, write commit on the next rising edge, plus the
//             mcycle/minstret 64-bit counters.
//  Options  : define CSR_COUNTER_EN to build the cycle/instret counters and
//             map their eight addresses; otherwise those addresses are
//             unmapped.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_reg_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        inst_retire_i,
  output logic        csr_illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MPIE[7], MIE[3]
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;  // M-mode only
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;  // MEIE, MTIE, MSIE
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;  // bit 1 reserved
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;  // IALIGN=32

`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  logic [31:0] mstatus_q,  mstatus_d;
  logic [31:0] mie_q,      mie_d;
  logic [31:0] mtvec_q,    mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q,     mepc_d;
  logic [31:0] mcause_q,   mcause_d;
  logic [31:0] mtval_q,    mtval_d;

  logic [31:0] rd_data;
  logic        rd_hit;
  logic        wr_legal;

  // Next value of the plain CSRs: masked write data on a matching write.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (csr_we_i) begin
      case (csr_waddr_i)
        ADDR_MSTATUS:  mstatus_d  = csr_wdata_i & MSTATUS_WMASK;
        ADDR_MIE:      mie_d      = csr_wdata_i & MIE_WMASK;
        ADDR_MTVEC:    mtvec_d    = csr_wdata_i & MTVEC_WMASK;
        ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
        ADDR_MEPC:     mepc_d     = csr_wdata_i & MEPC_WMASK;
        ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
        ADDR_MTVAL:    mtval_d    = csr_wdata_i;
        default:       ;
      endcase
    end
  end

  // Plain CSR state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_q  <= 32'd0;
      mie_q      <= 32'd0;
      mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q,   mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // Counter next value: free increment, or a half-load. A low-half load
  // freezes the high half; a high-half load lets the low half count but
  // drops its carry.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, inst_retire_i};
    if (csr_we_i) begin
      case (csr_waddr_i)
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wdata_i};
        ADDR_MCYCLEH:   mcycle_d   = {csr_wdata_i, mcycle_q[31:0] + 32'd1};
        ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wdata_i};
        ADDR_MINSTRETH: minstret_d = {csr_wdata_i,
                                      minstret_q[31:0] + {31'd0, inst_retire_i}};
        default:        ;
      endcase
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  // Retire strobe only feeds the counters; keep it visibly consumed.
  logic unused_retire;
  assign unused_retire = inst_retire_i;
`endif

  // Read decode: old value of the addressed CSR, no write bypass.
  always_comb begin
    rd_data = 32'd0;
    rd_hit  = 1'b1;
    case (csr_raddr_i)
      ADDR_MSTATUS:  rd_data = mstatus_q | MSTATUS_MPP;
      ADDR_MISA:     rd_data = MISA_VALUE;
      ADDR_MIE:      rd_data = mie_q;
      ADDR_MTVEC:    rd_data = mtvec_q;
      ADDR_MSCRATCH: rd_data = mscratch_q;
      ADDR_MEPC:     rd_data = mepc_q;
      ADDR_MCAUSE:   rd_data = mcause_q;
      ADDR_MTVAL:    rd_data = mtval_q;
      ADDR_MIP:      rd_data = 32'd0;
      ADDR_MHARTID:  rd_data = HART_ID;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE,    ADDR_CYCLE:    rd_data = mcycle_q[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   rd_data = mcycle_q[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  rd_data = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_data = minstret_q[63:32];
`endif
      default:       rd_hit  = 1'b0;
    endcase
  end

  // Write legality: only writable, mapped CSRs accept a write.
  always_comb begin
    wr_legal = 1'b0;
    case (csr_waddr_i)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
      ADDR_MEPC, ADDR_MCAUSE, ADDR_MTVAL: wr_legal = 1'b1;
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE, ADDR_MCYCLEH,
      ADDR_MINSTRET, ADDR_MINSTRETH:      wr_legal = 1'b1;
`endif
      default:                            wr_legal = 1'b0;
    endcase
  end

  // Outputs are held quiet while reset is asserted.
  assign csr_rdata_o   = rst_i ? 32'd0 : rd_data;
  assign csr_illegal_o = rst_i ? 1'b0  : (~rd_hit | (csr_we_i & ~wr_legal));

endmodule
`default_nettype wire

// File: tb/tb_csr_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_reg_file
//  Purpose  : Self-checking bench for csr_reg_file: directed steps followed
//             by randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_reg_file;

  localparam logic [31:0] HART  = 32'd7;
  localparam logic [31:0] MTVR  = 32'h8000_0003;
`ifdef CSR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ra;
  logic [31:0] rdata;
  logic        we;
  logic [11:0] wa;
  logic [31:0] wd;
  logic        ret;
  logic        illegal;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  csr_reg_file #(.HART_ID(HART), .MTVEC_RESET(MTVR)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_raddr_i  (ra),
    .csr_rdata_o  (rdata),
    .csr_we_i     (we),
    .csr_waddr_i  (wa),
    .csr_wdata_i  (wd),
    .inst_retire_i(ret),
    .csr_illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0;
    m_mtvec   = MTVR & ~32'h2;
    m_cycle   = 0;
    m_instret = 0;
  endtask

  function automatic bit model_is_counter(input logic [11:0] a);
    return (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82);
  endfunction

  function automatic bit model_wr_legal(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return 1'b1;
      default: return CNT_EN && model_is_counter(a);
    endcase
  endfunction

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output bit ok);
    ok = 1'b1;
    d  = 32'd0;
    case (a)
      12'h300: d = 32'h1800 | m_mstatus;
      12'h301: d = 32'h4000_0100;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = 32'd0;
      12'hF14: d = HART;
      12'hB00, 12'hC00: if (CNT_EN) d = m_cycle[31:0];    else ok = 1'b0;
      12'hB80, 12'hC80: if (CNT_EN) d = m_cycle[63:32];   else ok = 1'b0;
      12'hB02, 12'hC02: if (CNT_EN) d = m_instret[31:0];  else ok = 1'b0;
      12'hB82, 12'hC82: if (CNT_EN) d = m_instret[63:32]; else ok = 1'b0;
      default: ok = 1'b0;
    endcase
  endtask

  // Advance the model across one rising edge with the current inputs.
  task automatic model_edge();
    logic [63:0] nc, ni;
    nc = m_cycle + 64'd1;
    ni = m_instret + {63'd0, ret};
    if (we) begin
      case (wa)
        12'h300: m_mstatus  = wd & 32'h88;
        12'h304: m_mie      = wd & 32'h888;
        12'h305: m_mtvec    = wd & ~32'h2;
        12'h340: m_mscratch = wd;
        12'h341: m_mepc     = wd & ~32'h3;
        12'h342: m_mcause   = wd;
        12'h343: m_mtval    = wd;
        12'hB00: nc = {m_cycle[63:32], wd};
        12'hB80: nc = {wd, nc[31:0]};
        12'hB02: ni = {m_instret[63:32], wd};
        12'hB82: ni = {wd, ni[31:0]};
        default: ;
      endcase
    end
    m_cycle   = nc;
    m_instret = ni;
  endtask

  task automatic drive(input logic [11:0] r, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic rt);
    ra = r; we = w; wa = a; wd = d; ret = rt;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  // Compare both outputs against the model for the current inputs.
  task automatic check(input string tag);
    logic [31:0] ed;
    bit          ok;
    logic        ei;
    model_read(ra, ed, ok);
    ei = !ok || (we && !model_wr_legal(wa));
    if (rst) begin
      ed = 32'd0;
      ei = 1'b0;
    end
    vectors++;
    assert (rdata === ed) else begin
      miscompares++;
      $error("FAIL %s rdata raddr=%h got=%h exp=%h", tag, ra, rdata, ed);
    end
    vectors++;
    assert (illegal === ei) else begin
      miscompares++;
      $error("FAIL %s illegal raddr=%h we=%b waddr=%h got=%b exp=%b", tag, ra, we, wa, illegal, ei);
    end
  endtask

  // Compare outputs against literal values from the test plan.
  task automatic lit(input string tag, input logic [31:0] ed, input logic ei);
    vectors++;
    assert (rdata === ed) else begin
      miscompares++;
      $error("FAIL %s rdata got=%h exp=%h", tag, rdata, ed);
    end
    vectors++;
    assert (illegal === ei) else begin
      miscompares++;
      $error("FAIL %s illegal got=%b exp=%b", tag, illegal, ei);
    end
  endtask

  logic [11:0] addr_pool [0:21] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
    12'hC02, 12'hC82, 12'h7C0, 12'h302, 12'hB01, 12'hF11};

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom);
    return addr_pool[$urandom_range(0, 21)];
  endfunction

  initial begin
    rst = 1'b1;
    model_reset();
    ra = 12'h7C0; we = 1'b1; wa = 12'h301; wd = 32'd0; ret = 1'b0;
    #3;
    check("reset_quiet");
    lit("reset_quiet", 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    drive(12'h305, 1'b0, 12'h000, 32'd0, 1'b0); check("mtvec_rst");
    lit("mtvec_rst", 32'h8000_0001, 1'b0); tick();
    drive(12'h300, 1'b0, 12'h000, 32'd0, 1'b0); check("mstatus_rst");
    lit("mstatus_rst", 32'h0000_1800, 1'b0); tick();

    drive(12'h340, 1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0); check("csrrw_old");
    lit("csrrw_old", 32'd0, 1'b0); tick();
    drive(12'h340, 1'b0, 12'h000, 32'd0, 1'b0); check("csrrw_new");
    lit("csrrw_new", 32'hDEAD_BEEF, 1'b0); tick();

    drive(12'h300, 1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0); check("mstatus_wr"); tick();
    drive(12'h341, 1'b1, 12'h341, 32'hFFFF_FFFF, 1'b0); check("mepc_wr"); tick();
    drive(12'h300, 1'b0, 12'h000, 32'd0, 1'b0); check("mstatus_mask");
    lit("mstatus_mask", 32'h0000_1888, 1'b0); tick();
    drive(12'h341, 1'b0, 12'h000, 32'd0, 1'b0); check("mepc_mask");
    lit("mepc_mask", 32'hFFFF_FFFC, 1'b0); tick();
    drive(12'h304, 1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0); tick();
    drive(12'h304, 1'b0, 12'h000, 32'd0, 1'b0); lit("mie_mask", 32'h0000_0888, 1'b0); tick();

    drive(12'hF14, 1'b0, 12'h000, 32'd0, 1'b0); lit("mhartid", HART, 1'b0); tick();
    drive(12'h301, 1'b1, 12'h301, 32'h0, 1'b0); check("misa_ro");
    lit("misa_ro", 32'h4000_0100, 1'b1); tick();
    drive(12'h344, 1'b1, 12'h344, 32'hFFFF_FFFF, 1'b0); lit("mip_ro", 32'd0, 1'b1); tick();

    // cycle counter low-half load and wrap into the high half
    drive(12'hB00, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0); check("mcycle_wr"); tick();
    drive(12'hB00, 1'b0, 12'h000, 32'd0, 1'b0); check("mcycle_loaded"); tick();
    drive(12'hB00, 1'b0, 12'h000, 32'd0, 1'b0); check("mcycle_wrap"); tick();
    drive(12'hB80, 1'b0, 12'h000, 32'd0, 1'b0); check("mcycleh_carry"); tick();
    drive(12'hC00, 1'b1, 12'hC00, 32'h5555_5555, 1'b0); check("cycle_ro");
    lit("cycle_ro_ill", rdata, 1'b1); tick();
    drive(12'hC00, 1'b0, 12'h000, 32'd0, 1'b0); check("cycle_alias"); tick();
    drive(12'hB80, 1'b1, 12'hB80, 32'h1234_5678, 1'b0); check("mcycleh_wr"); tick();
    drive(12'hB80, 1'b0, 12'h000, 32'd0, 1'b0); check("mcycleh_loaded"); tick();
    drive(12'hB00, 1'b0, 12'h000, 32'd0, 1'b0); check("mcycle_after_h"); tick();

    // five retire pulses inside ten cycles
    for (int i = 0; i < 10; i++) begin
      drive(12'hB02, 1'b0, 12'h000, 32'd0, 1'(i % 2 == 0));
      check("minstret_run");
      tick();
    end
    drive(12'hB02, 1'b0, 12'h000, 32'd0, 1'b0); check("minstret_5");
    drive(12'hC02, 1'b0, 12'h000, 32'd0, 1'b0); check("instret_alias");

    // asynchronous reset mid-cycle
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_reset");
    lit("mid_reset", 32'd0, 1'b0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    ra  = 12'hB02;
    #1;
    check("post_reset_instret");
    ra = 12'h305;
    #1;
    lit("post_reset_mtvec", 32'h8000_0001, 1'b0);
    tick();
    drive(12'hB00, 1'b0, 12'h000, 32'd0, 1'b0); check("post_reset_cycle"); tick();
    drive(12'h340, 1'b0, 12'h000, 32'd0, 1'b0); lit("post_reset_mscratch", 32'd0, 1'b0); tick();

    drive(12'h7C0, 1'b0, 12'h000, 32'd0, 1'b0); check("unmapped");
    lit("unmapped", 32'd0, 1'b1); tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(pick_addr(), 1'($urandom_range(0, 1)), pick_addr(), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) wa = ra;
      #1;
      check("random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
